// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: funct codes, output tags,
// FSM state encoding and the single-cycle opcode classifier.
package alu_op_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  localparam logic [1:0] TAG_SINGLE = 2'd0;
  localparam logic [1:0] TAG_HI     = 2'd1;
  localparam logic [1:0] TAG_LO     = 2'd2;
  localparam logic [1:0] TAG_ERR    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RD_HI,
    S_RD_LO
  } state_t;

  // True for opcodes whose result is available combinationally in one cycle.
  function automatic logic is_single_cycle(input logic [5:0] funct);
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL: is_single_cycle = 1'b1;
      default:                                  is_single_cycle = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operation input, result output and ALU drive/return signals of the
// sequencer. slave is the sequencer's view, master the surrounding logic.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_ctrl;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_tag;
  logic             busy;

  modport slave (
    input  in_valid, in_ctrl, in_a, in_b, alu_result, out_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_data, out_tag, busy
  );

  modport master (
    output in_valid, in_ctrl, in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/alu_op_sequencer_out_slot.sv
// One-entry valid/ready result register. A capture in the same cycle as a
// pop replaces the entry with no bubble; the sequencer only captures when
// the slot is empty or being popped.
module alu_out_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic [1:0]       cap_tag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_tag
);

  // Load on capture, otherwise drain when the consumer takes the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 2'd0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= cap_data;
      out_tag   <= cap_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the multicycle ALU. Single-cycle ops run for one
// EXEC cycle; MULTU holds the ALU for MUL_WAIT cycles and then reads HI and
// LO back, each result landing in the output slot with its tag.
//
// state  | meaning
// IDLE   | ALU parked on AND, waiting for an op (bad codes answered here)
// EXEC   | single-cycle op on the ALU, result captured this cycle
// MUL    | MULTU held on the ALU while the wait counter runs down
// RD_HI  | MFHI on the ALU, waiting for a free slot to capture HI
// RD_LO  | MFLO on the ALU, waiting for a free slot to capture LO
module alu_op_sequencer
  import alu_op_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_WAIT = 35
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [5:0] CNT_INIT = 6'(MUL_WAIT - 1);

  state_t           state, state_nxt;
  logic [5:0]       cnt, cnt_nxt;
  logic [5:0]       op_ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic             slot_valid, slot_free, accept;
  logic             cap;
  logic [WIDTH-1:0] cap_data;
  logic [1:0]       cap_tag;
  logic [5:0]       alu_ctrl_c;

  assign slot_free    = !slot_valid || bus.out_ready;
  assign bus.in_ready = (state == S_IDLE) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.alu_ctrl = alu_ctrl_c;
  assign bus.alu_a    = op_a;
  assign bus.alu_b    = op_b;
  assign bus.busy     = (state != S_IDLE) || slot_valid;
  assign bus.out_valid = slot_valid;

  // State, wait counter and the latched operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      op_ctrl <= 6'd0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_ctrl <= bus.in_ctrl;
        op_a    <= bus.in_a;
        op_b    <= bus.in_b;
      end
    end
  end

  // Next state, ALU opcode and output-slot capture.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    alu_ctrl_c = F_AND;
    cap        = 1'b0;
    cap_data   = bus.alu_result;
    cap_tag    = TAG_SINGLE;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_single_cycle(bus.in_ctrl)) begin
            state_nxt = S_EXEC;
          end else if (bus.in_ctrl == F_MULTU) begin
            state_nxt = S_MUL;
            cnt_nxt   = CNT_INIT;
          end else begin
            cap      = 1'b1;
            cap_data = '0;
            cap_tag  = TAG_ERR;
          end
        end
      end
      S_EXEC: begin
        alu_ctrl_c = op_ctrl;
        cap        = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_MUL: begin
        alu_ctrl_c = F_MULTU;
        if (cnt == 6'd0) state_nxt = S_RD_HI;
        else             cnt_nxt   = cnt - 6'd1;
      end
      S_RD_HI: begin
        alu_ctrl_c = F_MFHI;
        if (slot_free) begin
          cap       = 1'b1;
          cap_tag   = TAG_HI;
          state_nxt = S_RD_LO;
        end
      end
      S_RD_LO: begin
        alu_ctrl_c = F_MFLO;
        if (slot_free) begin
          cap       = 1'b1;
          cap_tag   = TAG_LO;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  alu_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .cap_data  (cap_data),
    .cap_tag   (cap_tag),
    .out_ready (bus.out_ready),
    .out_valid (slot_valid),
    .out_data  (bus.out_data),
    .out_tag   (bus.out_tag)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stand-in, scoreboard fed on
// every accepted op, monitor popping on every taken result.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(32)) bus ();

  alu_op_sequencer #(.WIDTH(32), .MUL_WAIT(35)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  t;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   bad7    = 0;
  logic [31:0] hi_r = '0, lo_r = '0;
  logic [31:0] alu_res;
  logic        rnd_on = 1'b0;

  // Arithmetic meaning of each supported funct code.
  function automatic logic [31:0] op_value(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      6'd36:   op_value = a & b;
      6'd37:   op_value = a | b;
      6'd32:   op_value = a + b;
      6'd34:   op_value = a - b;
      6'd42:   op_value = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd0:    op_value = b << a[4:0];
      default: op_value = 32'd0;
    endcase
  endfunction

  // ALU stand-in: product register updated while MULTU is driven.
  always @(posedge clk) begin
    if (bus.alu_ctrl == 6'd25) {hi_r, lo_r} <= 64'(bus.alu_a) * 64'(bus.alu_b);
  end

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      6'd16:   alu_res = hi_r;
      6'd18:   alu_res = lo_r;
      default: alu_res = op_value(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    endcase
  end
  assign bus.alu_result = alu_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard push on accept, pop/compare on take, stall-stability check.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_tag;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.alu_ctrl == 6'd7) bad7++;
      if (bus.in_valid && bus.in_ready) begin
        logic [63:0] p;
        case (bus.in_ctrl)
          6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0:
            q.push_back('{op_value(bus.in_ctrl, bus.in_a, bus.in_b), 2'd0});
          6'd25: begin
            p = 64'(bus.in_a) * 64'(bus.in_b);
            q.push_back('{p[63:32], 2'd1});
            q.push_back('{p[31:0], 2'd2});
          end
          default: q.push_back('{32'd0, 2'd3});
        endcase
      end
      if (prev_stall) begin
        chk("stall_data", bus.out_data, prev_data);
        chk("stall_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got %0h/%0d expected none", bus.out_data, bus.out_tag);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_tag", 32'(bus.out_tag), 32'(e.t));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = bus.out_tag;
    end
  end

  // Offer an op until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ctl_tab [10];
    int n25, n;
    logic rdy_bad;
    ctl_tab = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd25, 6'd7, 6'd16, 6'd63};

    bus.in_valid  = 1'b0;
    bus.in_ctrl   = 6'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd36);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD latency and one-cycle ctrl
    send(6'd32, 32'd7, 32'd5);
    chk("add_ctrl", 32'(bus.alu_ctrl), 32'd32);
    chk("add_valid_early", 32'(bus.out_valid), 32'd0);
    cyc(1);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_data", bus.out_data, 32'd12);
    chk("add_in_ready", 32'(bus.in_ready), 32'd1);
    chk("add_ctrl_idle", 32'(bus.alu_ctrl), 32'd36);
    cyc(1);

    // back-to-back SUB, SLT
    send(6'd34, 32'd5, 32'd7);
    send(6'd42, 32'd3, 32'd9);
    cyc(3);

    // MULTU timing
    send(6'd25, 32'hFFFF_FFFF, 32'd2);
    n25 = 0;
    rdy_bad = 1'b0;
    while (bus.alu_ctrl == 6'd25 && n25 < 100) begin
      if (bus.in_ready) rdy_bad = 1'b1;
      n25++;
      cyc(1);
    end
    chk("mul_cycles", 32'(n25), 32'd35);
    chk("mul_in_ready", 32'(rdy_bad), 32'd0);
    chk("mfhi_ctrl", 32'(bus.alu_ctrl), 32'd16);
    chk("mfhi_in_ready", 32'(bus.in_ready), 32'd0);
    cyc(1);
    chk("hi_data", bus.out_data, 32'd1);
    chk("mflo_ctrl", 32'(bus.alu_ctrl), 32'd18);
    cyc(1);
    chk("lo_data", bus.out_data, 32'hFFFF_FFFE);
    chk("mul_done_ctrl", 32'(bus.alu_ctrl), 32'd36);
    cyc(2);

    // MULTU with HI back-pressured
    send(6'd25, 32'd100000, 32'd100000);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      n++;
      cyc(1);
    end
    chk("bp_hi_seen", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      chk("bp_hi_data", bus.out_data, 32'd2);
      chk("bp_hi_tag", 32'(bus.out_tag), 32'd1);
      chk("bp_ctrl", 32'(bus.alu_ctrl), 32'd18);
      cyc(1);
    end
    bus.out_ready = 1'b1;
    cyc(1);
    chk("bp_lo_data", bus.out_data, 32'h540B_E400);
    chk("bp_lo_tag", 32'(bus.out_tag), 32'd2);
    cyc(2);

    // unsupported code
    send(6'd7, 32'd1, 32'd2);
    chk("err_valid", 32'(bus.out_valid), 32'd1);
    chk("err_data", bus.out_data, 32'd0);
    chk("err_tag", 32'(bus.out_tag), 32'd3);
    cyc(2);

    // reset in the middle of MULTU (counter at 10)
    send(6'd25, 32'd3, 32'd4);
    cyc(24);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    q.delete();
    chk("mrst_ctrl", 32'(bus.alu_ctrl), 32'd36);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    cyc(60);
    send(6'd36, 32'hF0, 32'h3C);
    cyc(1);
    chk("and_after_rst", bus.out_data, 32'h30);
    cyc(2);

    // randomized ops with random consumer back-pressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(ctl_tab[$urandom_range(0, 9)], $urandom, $urandom);
          cyc($urandom_range(0, 2));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join

    n = 0;
    while (q.size() != 0 && n < 500) begin
      n++;
      cyc(1);
    end
    cyc(2);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("ctrl7_never", 32'(bad7), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
